// File: rtl/dmem_line_ctrl_if.sv
// dmem_line_ctrl_if: request/response bus between the L1 miss FSM (master) and the line memory (slave).
interface dmem_line_ctrl_if;
    logic         enable_i;
    logic         write_i;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         ack_o;
    logic [255:0] data_o;
    logic [31:0]  rd_cnt_o;
    logic [31:0]  wr_cnt_o;
    modport master (output enable_i, write_i, addr_i, data_i, input ack_o, data_o, rd_cnt_o, wr_cnt_o);
    modport slave (input enable_i, write_i, addr_i, data_i, output ack_o, data_o, rd_cnt_o, wr_cnt_o);
endinterface

// File: rtl/dmem_line_ctrl.sv
// dmem_line_ctrl: 256-bit line memory with a fixed-latency countdown and a one-cycle ack pulse.
// Optional read/write completion counters are enabled by defining DMEM_PERF_CNT_EN.
module dmem_line_ctrl #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512,
    parameter int IDX_W   = 9
) (
    input  logic            clk_i,
    input  logic            rst_i,
    dmem_line_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               wr_q, wr_d;
    logic [255:0]       wdata_q, wdata_d;
    logic [255:0]       rdata_q, rdata_d;
    logic               ack_q, ack_d;
    logic               done;
    logic [255:0]       mem_q [DEPTH];
    logic               unused_addr;

    assign unused_addr = ^{bus.addr_i[31:IDX_W+5], bus.addr_i[4:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: if (bus.enable_i) begin
                state_d = BUSY;
                cnt_d   = 8'(LATENCY - 1);
                idx_d   = bus.addr_i[IDX_W+4:5];
                wr_d    = bus.write_i;
                wdata_d = bus.data_i;
            end
            BUSY: if (cnt_q != 8'd0) begin
                cnt_d = cnt_q - 8'd1;
            end else begin
                done    = 1'b1;
                state_d = ACK;
                ack_d   = 1'b1;
                rdata_d = wr_q ? rdata_q : mem_q[idx_q];
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
        end
    end

    // Gating on rst_i keeps a reset that lands on the final BUSY edge from committing the write.
    always_ff @(posedge clk_i) begin
        if (rst_i && done && wr_q) mem_q[idx_q] <= wdata_q;
    end

    assign bus.ack_o  = ack_q;
    assign bus.data_o = rdata_q;

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
        end else if (done) begin
            rd_cnt_q <= rd_cnt_q + {31'd0, !wr_q};
            wr_cnt_q <= wr_cnt_q + {31'd0, wr_q};
        end
    end
    assign bus.rd_cnt_o = rd_cnt_q;
    assign bus.wr_cnt_o = wr_cnt_q;
`else
    assign bus.rd_cnt_o = 32'd0;
    assign bus.wr_cnt_o = 32'd0;
`endif
endmodule
